// File: rtl/pipe_reg.sv
// Valid/ready register pipeline of STAGES stages with bubble collapsing and synchronous flush.
// Latency STAGES cycles; back-pressure ripples through adv[] so any empty stage still fills.
module pipe_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    STAGES     = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          flush,
    output logic [$clog2(STAGES+1)-1:0]   count
);

    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0]     valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [DATA_WIDTH-1:0] data_d [STAGES];
    logic [CW-1:0]         count_q, count_d;

    logic [STAGES:0]       adv;
    logic [STAGES:0]       vld_chain;
    logic [DATA_WIDTH-1:0] dat_chain [STAGES+1];
    logic                  in_fire;
    logic                  out_fire;

    // A stage may advance when it is empty or everything downstream of it moves.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = !valid_q[i] || adv[i+1];
        end
    end

    assign in_ready = adv[0] && !flush;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q[STAGES-1] && out_ready;

    // Stage i is fed from chain slot i: slot 0 is the input port, slot i+1 is stage i.
    always_comb begin
        vld_chain    = {valid_q, in_fire};
        dat_chain[0] = in_data;
        for (int i = 0; i < STAGES; i++) begin
            dat_chain[i+1] = data_q[i];
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < STAGES; i++) begin
            if (adv[i]) begin
                valid_d[i] = vld_chain[i];
            end
            if (adv[i] && vld_chain[i]) begin
                data_d[i] = dat_chain[i];
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        count_d = count_q + CW'(in_fire) - CW'(out_fire);
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= RESET_DATA;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: a 3-stage and a 1-stage instance against a queue-based timing model.
module tb_pipe_reg;

    localparam int          DW  = 32;
    localparam logic [31:0] RD3 = 32'h5A5A_0F0F;
    localparam logic [31:0] RD1 = 32'h0000_1234;

    logic          clk;
    logic          rst;
    logic          in_valid3, in_ready3, out_valid3, out_ready3, flush3;
    logic [DW-1:0] in_data3, out_data3;
    logic [1:0]    count3;
    logic          in_valid1, in_ready1, out_valid1, out_ready1, flush1;
    logic [DW-1:0] in_data1, out_data1;
    logic [0:0]    count1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] d;
        int          acc;
    } beat_t;

    beat_t sbq [2][$];
    int    last_dep [2];

    pipe_reg #(.DATA_WIDTH(DW), .STAGES(3), .RESET_DATA(RD3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .flush(flush3), .count(count3)
    );

    pipe_reg #(.DATA_WIDTH(DW), .STAGES(1), .RESET_DATA(RD1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .flush(flush1), .count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: held beats form a FIFO of depth stg. A beat accepted in cycle a becomes
    // visible at the output no earlier than a+stg, and never before the cycle after
    // its predecessor departed.
    task automatic model_step(input int id, input int stg, input logic [31:0] rdat,
                              input logic r, input logic fl, input logic iv, input logic ir,
                              input logic ov, input logic ordy, input logic [31:0] idat,
                              input logic [31:0] od, input int cnt);
        string tag;
        int    vis;
        logic  exp_ov;
        logic  exp_ir;
        tag = (id == 0) ? "s3" : "s1";
        if (r) begin
            chk({tag, "_rst_out_valid"}, ov, 0);
            chk({tag, "_rst_count"}, cnt, 0);
            chk({tag, "_rst_out_data"}, od, rdat);
            chk({tag, "_rst_in_ready"}, ir, !fl);
            sbq[id].delete();
            last_dep[id] = -1000;
            return;
        end
        exp_ov = 1'b0;
        if (sbq[id].size() > 0) begin
            vis = sbq[id][0].acc + stg;
            if (last_dep[id] + 1 > vis) vis = last_dep[id] + 1;
            exp_ov = (cyc >= vis);
        end
        exp_ir = !fl && ((sbq[id].size() < stg) || ordy);
        chk({tag, "_out_valid"}, ov, exp_ov);
        chk({tag, "_in_ready"}, ir, exp_ir);
        chk({tag, "_count"}, cnt, sbq[id].size());
        if (exp_ov) chk({tag, "_out_data"}, od, sbq[id][0].d);
        if (exp_ov && ordy) begin
            void'(sbq[id].pop_front());
            last_dep[id] = cyc;
        end
        if (fl) sbq[id].delete();
        else if (iv && exp_ir) sbq[id].push_back('{d: idat, acc: cyc});
    endtask

    always @(negedge clk) begin
        model_step(0, 3, RD3, rst, flush3, in_valid3, in_ready3, out_valid3, out_ready3,
                   in_data3, out_data3, int'(count3));
        model_step(1, 1, RD1, rst, flush1, in_valid1, in_ready1, out_valid1, out_ready1,
                   in_data1, out_data1, int'(count1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain3();
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
        flush3     = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        last_dep[0] = -1000;
        last_dep[1] = -1000;
        rst = 1'b1;
        in_valid3 = 0; in_data3 = '0; out_ready3 = 0; flush3 = 0;
        in_valid1 = 0; in_data1 = '0; out_ready1 = 0; flush1 = 0;
        repeat (2) step();
        rst = 1'b0;

        // Streaming at full rate.
        out_ready3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid3 = 1'b1;
            in_data3  = 32'hA0 + i;
            step();
        end
        drain3();

        // Backpressure until full, then simultaneous accept and emit.
        out_ready3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid3 = 1'b1;
            in_data3  = 32'hB0 + i;
            step();
        end
        in_data3 = 32'hB3;
        #2;
        chk("bp_count_full", count3, 3);
        chk("bp_in_ready_full", in_ready3, 0);
        chk("bp_out_data_head", out_data3, 32'hB0);
        step();
        chk("bp_out_data_stable", out_data3, 32'hB0);
        out_ready3 = 1'b1;
        #2;
        chk("bp_in_ready_release", in_ready3, 1);
        step();
        drain3();

        // Bubble collapse behind a stalled head.
        out_ready3 = 1'b0;
        in_valid3 = 1'b1; in_data3 = 32'hC0; step();
        in_valid3 = 1'b0; repeat (2) step();
        in_valid3 = 1'b1; in_data3 = 32'hC1; step();
        in_valid3 = 1'b0; repeat (3) step();
        chk("bubble_count", count3, 2);
        chk("bubble_head", out_data3, 32'hC0);
        drain3();

        // Flush with a competing input beat.
        out_ready3 = 1'b0;
        in_valid3 = 1'b1; in_data3 = 32'hD0; step();
        in_data3 = 32'hD1; step();
        in_data3 = 32'hD2; flush3 = 1'b1;
        #2;
        chk("flush_in_ready", in_ready3, 0);
        step();
        flush3 = 1'b0; in_valid3 = 1'b0;
        #2;
        chk("flush_count", count3, 0);
        chk("flush_out_valid", out_valid3, 0);
        drain3();

        // Asynchronous reset between edges with three beats held.
        out_ready3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid3 = 1'b1;
            in_data3  = 32'h70 + i;
            step();
        end
        in_valid3 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid3, 0);
        chk("arst_count", count3, 0);
        chk("arst_out_data", out_data3, RD3);
        step();
        rst = 1'b0;
        out_ready3 = 1'b1;
        in_valid3 = 1'b1; in_data3 = 32'h77; step();
        drain3();

        // Single-stage instance.
        out_ready1 = 1'b1;
        in_valid1 = 1'b1; in_data1 = 32'hE0; step();
        in_valid1 = 1'b0;
        #2;
        chk("s1_out_valid", out_valid1, 1);
        chk("s1_out_data", out_data1, 32'hE0);
        step();
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_data1 = 32'hE1; step();
        in_data1 = 32'hE2;
        #2;
        chk("s1_in_ready_held", in_ready1, 0);
        step();
        out_ready1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        repeat (3) step();

        // Randomised traffic on both instances.
        for (int n = 0; n < 600; n++) begin
            in_valid3  = 1'($urandom_range(0, 1));
            in_data3   = $urandom;
            out_ready3 = ($urandom_range(0, 9) < 7);
            flush3     = ($urandom_range(0, 39) == 0);
            in_valid1  = 1'($urandom_range(0, 1));
            in_data1   = $urandom;
            out_ready1 = ($urandom_range(0, 9) < 6);
            flush1     = ($urandom_range(0, 39) == 0);
            rst        = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        drain3();
        chk("final_count3", count3, 0);
        chk("final_count1", count1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
